// File: rtl/ex_mdu_stage_pkg.sv
// Shared constants for the EX stage: opcodes, result classes and divider state encodings.
// The EX_DIV_EN build option (see ex_mdu_stage.sv) is what uses the divider items.
package ex_mdu_stage_pkg;

  localparam int   REG_BUS_W  = 32;
  localparam logic RST_ENABLE = 1'b1;
  localparam int   DIV_CYCLES = 32;

  localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
  localparam logic [7:0] EXE_MOVZ_OP  = 8'b0000_1010;
  localparam logic [7:0] EXE_MOVN_OP  = 8'b0000_1011;
  localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [2:0] EXE_RES_MOVE  = 3'b011;

  typedef enum logic [1:0] {
    DivFree = 2'd0,
    DivOn   = 2'd1,
    DivEnd  = 2'd2
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  function automatic logic [REG_BUS_W-1:0] abs_val(input logic [REG_BUS_W-1:0] v,
                                                   input logic is_signed);
    return (is_signed && v[REG_BUS_W-1]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_mdu_stage_div_unit.sv
// Iterative restoring divider, one quotient bit per cycle; result is {remainder, quotient}.
// Signs are stripped on start and reapplied combinationally while the result is presented.
module ex_mdu_stage_div_unit
  import ex_mdu_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic                   signed_div_i,
  input  logic [REG_BUS_W-1:0]   opdata1_i,
  input  logic [REG_BUS_W-1:0]   opdata2_i,
  input  logic                   cancel_i,
  input  logic                   hold_i,
  output logic [2*REG_BUS_W-1:0] result_o,
  output logic                   ready_o,
  output div_state_e             state_o
);

  div_state_e           state_q, state_d;
  logic [5:0]           cnt_q, cnt_d;
  logic [REG_BUS_W-1:0] rem_q, rem_d;
  logic [REG_BUS_W-1:0] quo_q, quo_d;
  logic [REG_BUS_W-1:0] dvs_q, dvs_d;
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;

  logic [REG_BUS_W:0]   rem_sh;
  logic [REG_BUS_W:0]   diff;

  assign rem_sh = {rem_q, quo_q[REG_BUS_W-1]};
  assign diff   = rem_sh - {1'b0, dvs_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    case (state_q)
      DivFree: begin
        if (start_i && !cancel_i) begin
          if (opdata2_i == '0) begin
            // Divide by zero: quotient all ones, remainder is the raw dividend.
            rem_d     = opdata1_i;
            quo_d     = '1;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
            state_d   = DivEnd;
          end else begin
            rem_d     = '0;
            quo_d     = abs_val(opdata1_i, signed_div_i);
            dvs_d     = abs_val(opdata2_i, signed_div_i);
            cnt_d     = '0;
            neg_quo_d = signed_div_i && (opdata1_i[REG_BUS_W-1] ^ opdata2_i[REG_BUS_W-1]);
            neg_rem_d = signed_div_i && opdata1_i[REG_BUS_W-1];
            state_d   = DivOn;
          end
        end
      end
      DivOn: begin
        if (cancel_i) begin
          state_d = DivFree;
        end else begin
          if (!diff[REG_BUS_W]) begin
            rem_d = diff[REG_BUS_W-1:0];
            quo_d = {quo_q[REG_BUS_W-2:0], 1'b1};
          end else begin
            rem_d = rem_sh[REG_BUS_W-1:0];
            quo_d = {quo_q[REG_BUS_W-2:0], 1'b0};
          end
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'(DIV_CYCLES - 1)) state_d = DivEnd;
        end
      end
      DivEnd: begin
        if (cancel_i || !hold_i) state_d = DivFree;
      end
      default: state_d = DivFree;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q   <= DivFree;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign result_o = {(neg_rem_q ? (~rem_q + 32'd1) : rem_q),
                     (neg_quo_q ? (~quo_q + 32'd1) : quo_q)};
  assign ready_o  = (state_q == DivEnd) ? DivResultReady : DivResultNotReady;
  assign state_o  = state_q;

endmodule

// File: rtl/ex_mdu_stage.sv
// Execute stage with HI/LO, single-cycle MULT/MULTU and an optional iterative DIV/DIVU.
// Define EX_DIV_EN to build the divider; otherwise DIV/DIVU are NOPs and stall_req_o is 0.
module ex_mdu_stage
  import ex_mdu_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stall_req_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] result;
  logic [63:0] mul_s;
  logic [63:0] mul_u;

  // Sign-extended 64x64 multiply keeps the low 64 bits equal to the signed product.
  assign mul_s = {{32{reg1_i[31]}}, reg1_i} * {{32{reg2_i[31]}}, reg2_i};
  assign mul_u = {32'd0, reg1_i} * {32'd0, reg2_i};

  always_comb begin
    result = '0;
    case (alusel_i)
      EXE_RES_LOGIC: begin
        case (aluop_i)
          EXE_OR_OP:  result = reg1_i | reg2_i;
          EXE_AND_OP: result = reg1_i & reg2_i;
          EXE_XOR_OP: result = reg1_i ^ reg2_i;
          EXE_NOR_OP: result = ~(reg1_i | reg2_i);
          default:    result = '0;
        endcase
      end
      EXE_RES_SHIFT: begin
        case (aluop_i)
          EXE_SLL_OP: result = reg2_i << reg1_i[4:0];
          EXE_SRL_OP: result = reg2_i >> reg1_i[4:0];
          EXE_SRA_OP: result = $unsigned($signed(reg2_i) >>> reg1_i[4:0]);
          default:    result = '0;
        endcase
      end
      EXE_RES_MOVE: begin
        case (aluop_i)
          EXE_MFHI_OP: result = hi_q;
          EXE_MFLO_OP: result = lo_q;
          EXE_MOVN_OP,
          EXE_MOVZ_OP: result = reg1_i;
          default:     result = '0;
        endcase
      end
      default: result = '0;
    endcase
  end

`ifdef EX_DIV_EN
  logic        div_start;
  logic        div_ready;
  logic [63:0] div_result;
  div_state_e  div_state;

  assign div_start = ((aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP)) && !flush_i;

  ex_mdu_stage_div_unit u_div (
    .clk          (clk),
    .rst          (rst),
    .start_i      (div_start),
    .signed_div_i (aluop_i == EXE_DIV_OP),
    .opdata1_i    (reg1_i),
    .opdata2_i    (reg2_i),
    .cancel_i     (flush_i),
    .hold_i       (stall_i),
    .result_o     (div_result),
    .ready_o      (div_ready),
    .state_o      (div_state)
  );

  // The result cycle (DivEnd) releases the stall so the pipeline can retire the divide.
  assign stall_req_o = (rst != RST_ENABLE) &&
                       (((div_state == DivFree) && div_start) || (div_state == DivOn));
`else
  assign stall_req_o = 1'b0;
`endif

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (!stall_i && !flush_i) begin
      case (aluop_i)
        EXE_MTHI_OP:  hi_d = reg1_i;
        EXE_MTLO_OP:  lo_d = reg1_i;
        EXE_MULT_OP:  {hi_d, lo_d} = mul_s;
        EXE_MULTU_OP: {hi_d, lo_d} = mul_u;
        default: ;
      endcase
`ifdef EX_DIV_EN
      if (div_ready == DivResultReady) {hi_d, lo_d} = div_result;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign wd_o    = (rst == RST_ENABLE) ? 5'd0  : wd_i;
  assign wreg_o  = (rst == RST_ENABLE) ? 1'b0  : wreg_i;
  assign wdata_o = (rst == RST_ENABLE) ? 32'd0 : result;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: tb/tb_ex_mdu_stage.sv
// Directed bench for ex_mdu_stage; divide expectations follow whether EX_DIV_EN is defined.
module tb_ex_mdu_stage;
  import ex_mdu_stage_pkg::*;

`ifdef EX_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic        stall_i;
  logic        flush_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stall_req_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int checks   = 0;
  int failures = 0;
  int n;

  ex_mdu_stage dut (
    .clk         (clk),
    .rst         (rst),
    .aluop_i     (aluop_i),
    .alusel_i    (alusel_i),
    .reg1_i      (reg1_i),
    .reg2_i      (reg2_i),
    .wd_i        (wd_i),
    .wreg_i      (wreg_i),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .wd_o        (wd_o),
    .wreg_o      (wreg_o),
    .wdata_o     (wdata_o),
    .stall_req_o (stall_req_o),
    .hi_o        (hi_o),
    .lo_o        (lo_o)
  );

  // Clock/reset: 10-unit period; reset is driven from the stimulus block.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [4:0] wd, input logic wreg);
    aluop_i  = op;
    alusel_i = sel;
    reg1_i   = r1;
    reg2_i   = r2;
    wd_i     = wd;
    wreg_i   = wreg;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    drive(EXE_OR_OP, EXE_RES_LOGIC, 32'h0000FF00, 32'h00FF00FF, 5'd9, 1'b1);
    tick(); tick(); #1;
    chk("rst_wdata", wdata_o, 0);
    chk("rst_wreg",  wreg_o, 0);
    chk("rst_wd",    wd_o, 0);
    chk("rst_hi",    hi_o, 0);
    chk("rst_lo",    lo_o, 0);
    drive(EXE_DIV_OP, EXE_RES_NOP, 32'd7, 32'd2, 5'd0, 1'b0);
    #1 chk("rst_stall", stall_req_o, 0);

    tick(); rst = 1'b0;
    tick();
    drive(EXE_OR_OP, EXE_RES_LOGIC, 32'h0000FF00, 32'h00FF00FF, 5'd5, 1'b1);
    #1 chk("or", wdata_o, 32'h00FFFFFF);
    chk("or_wd", wd_o, 5);
    chk("or_wreg", wreg_o, 1);
    drive(EXE_NOR_OP, EXE_RES_LOGIC, 32'h0000FF00, 32'h00FF00FF, 5'd5, 1'b1);
    #1 chk("nor", wdata_o, 32'hFF000000);
    drive(EXE_AND_OP, EXE_RES_LOGIC, 32'h0000FF00, 32'h00FF0FFF, 5'd5, 1'b1);
    #1 chk("and", wdata_o, 32'h00000F00);
    drive(EXE_SRA_OP, EXE_RES_SHIFT, 32'd4, 32'h80000010, 5'd6, 1'b1);
    #1 chk("sra", wdata_o, 32'hF8000001);
    drive(EXE_SRL_OP, EXE_RES_SHIFT, 32'd4, 32'h80000010, 5'd6, 1'b1);
    #1 chk("srl", wdata_o, 32'h08000001);
    drive(EXE_SLL_OP, EXE_RES_SHIFT, 32'd4, 32'h80000010, 5'd6, 1'b1);
    #1 chk("sll", wdata_o, 32'h00000100);
    drive(EXE_OR_OP, 3'b111, 32'h0000FF00, 32'h00FF00FF, 5'd5, 1'b1);
    #1 chk("bad_sel", wdata_o, 0);

    tick();
    drive(EXE_MTHI_OP, EXE_RES_NOP, 32'h12345678, 32'd0, 5'd0, 1'b0);
    #1 chk("mthi_wdata", wdata_o, 0);
    chk("mthi_no_bypass", hi_o, 0);
    tick();
    drive(EXE_MFHI_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd3, 1'b1);
    #1 chk("mfhi", wdata_o, 32'h12345678);
    chk("mfhi_wreg", wreg_o, 1);
    chk("mfhi_wd", wd_o, 3);

    tick();
    drive(EXE_MTLO_OP, EXE_RES_NOP, 32'hDEADBEEF, 32'd0, 5'd0, 1'b0);
    stall_i = 1'b1;
    tick(); stall_i = 1'b0; flush_i = 1'b1;
    #1 chk("mtlo_stall", lo_o, 0);
    tick(); flush_i = 1'b0;
    drive(EXE_MFLO_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd4, 1'b1);
    #1 chk("mtlo_flush", wdata_o, 0);
    drive(EXE_MOVN_OP, EXE_RES_MOVE, 32'hA5A5A5A5, 32'd1, 5'd4, 1'b1);
    #1 chk("movn", wdata_o, 32'hA5A5A5A5);

    tick();
    drive(EXE_MULT_OP, EXE_RES_NOP, 32'hFFFFFFFE, 32'd3, 5'd0, 1'b0);
    #1 chk("mult_wdata", wdata_o, 0);
    tick();
    drive(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    #1 chk("mult", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFFA);
    drive(EXE_MULTU_OP, EXE_RES_NOP, 32'hFFFFFFFE, 32'd3, 5'd0, 1'b0);
    tick();
    drive(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    #1 chk("multu", {hi_o, lo_o}, 64'h00000002_FFFFFFFA);

    // Signed divide -7 / 2: count the consecutive stall cycles.
    drive(EXE_DIV_OP, EXE_RES_NOP, 32'hFFFFFFF9, 32'd2, 5'd0, 1'b0);
    #1 n = 0;
    while (stall_req_o === 1'b1 && n < 100) begin
      n++;
      @(posedge clk);
      #2;
    end
    chk("div_stall_len", n, DIV_ON ? 33 : 0);
    chk("div_pre_write", {hi_o, lo_o}, 64'h00000002_FFFFFFFA);
    tick();
    drive(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    #1 chk("div", {hi_o, lo_o}, DIV_ON ? 64'hFFFFFFFF_FFFFFFFD : 64'h00000002_FFFFFFFA);

    // Unsigned divide by zero with a downstream stall during the result cycle.
    drive(EXE_DIVU_OP, EXE_RES_NOP, 32'd7, 32'd0, 5'd0, 1'b0);
    #1 chk("divz_stall", stall_req_o, DIV_ON);
    tick();
    #1 chk("divz_done_stall", stall_req_o, 0);
    stall_i = 1'b1;
    tick(); stall_i = 1'b0;
    #1 chk("divz_hold", {hi_o, lo_o}, DIV_ON ? 64'hFFFFFFFF_FFFFFFFD : 64'h00000002_FFFFFFFA);
    tick();
    drive(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    #1 chk("divz", {hi_o, lo_o}, DIV_ON ? 64'h00000007_FFFFFFFF : 64'h00000002_FFFFFFFA);

    // Flush in the tenth busy cycle.
    drive(EXE_DIV_OP, EXE_RES_NOP, 32'd100, 32'd3, 5'd0, 1'b0);
    repeat (10) tick();
    flush_i = 1'b1;
    drive(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    tick(); flush_i = 1'b0;
    #1 chk("flush_stall", stall_req_o, 0);
    repeat (30) tick();
    chk("flush_hilo", {hi_o, lo_o}, DIV_ON ? 64'h00000007_FFFFFFFF : 64'h00000002_FFFFFFFA);

    // Reset in the middle of a division.
    drive(EXE_DIV_OP, EXE_RES_NOP, 32'd100, 32'd3, 5'd0, 1'b0);
    repeat (5) tick();
    rst = 1'b1;
    drive(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    tick(); rst = 1'b0;
    #1 chk("rst_busy_hilo", {hi_o, lo_o}, 0);
    chk("rst_busy_stall", stall_req_o, 0);
    drive(EXE_DIVU_OP, EXE_RES_NOP, 32'd7, 32'd0, 5'd0, 1'b0);
    #1 chk("rst_idle_start", stall_req_o, DIV_ON);
    tick();
    #1 chk("rst_idle_done", stall_req_o, 0);
    tick();
    drive(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    #1 chk("rst_then_divz", {hi_o, lo_o}, DIV_ON ? 64'h00000007_FFFFFFFF : 64'd0);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
